// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA raster timing generator: the default 800x600@56Hz raster
// geometry (36 MHz pixel clock), coordinate and colour types, and the colour-bar test-pattern
// helpers used when VGA_TEST_PATTERN_EN is defined.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE = 800;
  localparam int unsigned H_FP     = 24;
  localparam int unsigned H_SYNC   = 72;
  localparam int unsigned H_BP     = 128;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 600;
  localparam int unsigned V_FP     = 1;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 22;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Width of one test-pattern colour bar, in pixels.
  localparam int unsigned BAR_WIDTH = 100;

  typedef logic [10:0] h_coord_t;
  typedef logic [9:0]  v_coord_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // h / BAR_WIDTH for the active area, built as a compare ladder instead of a divider.
  function automatic logic [2:0] bar_index(input h_coord_t h);
    logic [2:0] idx;
    idx = 3'd0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (h >= h_coord_t'(i * BAR_WIDTH)) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic rgb444_t bar_colour(input logic [2:0] idx);
    rgb444_t c;
    c.r = {4{idx[0]}};
    c.g = {4{idx[1]}};
    c.b = {4{idx[2]}};
    return c;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a free-running counter 0..TOTAL-1 that advances when en is high, flags the
// last position of the axis (wrap) and decodes the sync window [SYNC_START, SYNC_END).
// Ports:
//   pixel_clk  in   pixel clock
//   rst_n      in   asynchronous active-low reset, counter clears to 0
//   en         in   advance the counter this clock
//   count      out  current position
//   wrap       out  en is high and count is TOTAL-1 (counter returns to 0 on this clock)
//   in_sync    out  count lies inside the sync window
module vga_axis_counter #(
  parameter int unsigned WIDTH      = 11,
  parameter int unsigned TOTAL      = 1024,
  parameter int unsigned SYNC_START = 824,
  parameter int unsigned SYNC_END   = 896
) (
  input  logic             pixel_clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             in_sync
);

  logic [WIDTH-1:0] count_q, count_d;

  assign wrap    = en && (count_q == WIDTH'(TOTAL - 1));
  assign in_sync = (count_q >= WIDTH'(SYNC_START)) && (count_q < WIDTH'(SYNC_END));
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    if (wrap) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator (default 800x600@56Hz, 36 MHz pixel clock). Drives the current pixel
// coordinate to the drawing plane, takes its 4-bit RGB back in the same cycle, and registers
// blanked colour plus sync for the VGA pins, so colour and sync arrive at the pins together one
// clock after the coordinate.
// Build option: define VGA_TEST_PATTERN_EN to replace the plane colour in the active area with
// eight 100-pixel vertical colour bars; timing and latency do not change.
// Ports:
//   pixel_clk            in   pixel clock
//   rst_n                in   asynchronous active-low reset
//   h_coord, v_coord     out  current raster position
//   display_on           out  position is inside the active area
//   frame_start          out  position is (0,0)
//   red, green, blue     in   plane colour for the current position
//   vga_r, vga_g, vga_b  out  registered, blanked colour
//   vga_hs, vga_vs       out  registered sync, active level set by SYNC_POS
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
  parameter bit          SYNC_POS = 1'b1
) (
  input  logic                     pixel_clk,
  input  logic                     rst_n,
  output vga_timing_pkg::h_coord_t h_coord,
  output vga_timing_pkg::v_coord_t v_coord,
  output logic                     display_on,
  output logic                     frame_start,
  input  logic [3:0]               red,
  input  logic [3:0]               green,
  input  logic [3:0]               blue,
  output logic [3:0]               vga_r,
  output logic [3:0]               vga_g,
  output logic [3:0]               vga_b,
  output logic                     vga_hs,
  output logic                     vga_vs
);

  import vga_timing_pkg::*;

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic h_wrap, h_in_sync;
  logic v_wrap, v_in_sync;

  vga_axis_counter #(
    .WIDTH      ($bits(h_coord_t)),
    .TOTAL      (HTotal),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
  ) u_h_counter (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .en        (1'b1),
    .count     (h_coord),
    .wrap      (h_wrap),
    .in_sync   (h_in_sync)
  );

  // The vertical axis steps once per line, on the clock the horizontal axis wraps.
  vga_axis_counter #(
    .WIDTH      ($bits(v_coord_t)),
    .TOTAL      (VTotal),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
  ) u_v_counter (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .en        (h_wrap),
    .count     (v_coord),
    .wrap      (v_wrap),
    .in_sync   (v_in_sync)
  );

  // End-of-frame flag is not needed here; frame_start is decoded from the coordinates.
  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;

  assign display_on  = (h_coord < h_coord_t'(H_ACTIVE)) && (v_coord < v_coord_t'(V_ACTIVE));
  assign frame_start = (h_coord == '0) && (v_coord == '0);

  rgb444_t pix_d, pix_q;
  logic    hs_q, vs_q;

`ifdef VGA_TEST_PATTERN_EN
  logic unused_plane_rgb;
  assign unused_plane_rgb = ^{red, green, blue};
`endif

  always_comb begin
    pix_d = '0;
    if (display_on) begin
`ifdef VGA_TEST_PATTERN_EN
      pix_d = bar_colour(bar_index(h_coord));
`else
      pix_d = '{r: red, g: green, b: blue};
`endif
    end
  end

  // Colour and sync share one register stage so they stay aligned at the connector.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q <= '0;
      hs_q  <= ~SYNC_POS;
      vs_q  <= ~SYNC_POS;
    end else begin
      pix_q <= pix_d;
      hs_q  <= SYNC_POS ~^ h_in_sync;
      vs_q  <= SYNC_POS ~^ v_in_sync;
    end
  end

  assign vga_r  = pix_q.r;
  assign vga_g  = pix_q.g;
  assign vga_b  = pix_q.b;
  assign vga_hs = hs_q;
  assign vga_vs = vs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
module tb_vga_timing_gen;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        disp;
    logic        fs;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        hs;
    logic        vs;
  } snap_t;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit pol;
  } geom_t;

  // Reduced raster for a second instance so frame-level timing fits a short run.
  localparam int unsigned SH_ACTIVE = 16;
  localparam int unsigned SH_FP     = 2;
  localparam int unsigned SH_SYNC   = 3;
  localparam int unsigned SH_BP     = 3;
  localparam int unsigned SV_ACTIVE = 6;
  localparam int unsigned SV_FP     = 1;
  localparam int unsigned SV_SYNC   = 2;
  localparam int unsigned SV_BP     = 2;
  localparam int          S_HT      = SH_ACTIVE + SH_FP + SH_SYNC + SH_BP;
  localparam int          S_VT      = SV_ACTIVE + SV_FP + SV_SYNC + SV_BP;

  logic       pixel_clk = 1'b0;
  logic       rst_n;
  logic [3:0] red, green, blue;

  logic [10:0] f_h, s_h;
  logic [9:0]  f_v, s_v;
  logic        f_disp, f_fs, s_disp, s_fs;
  logic [3:0]  f_r, f_g, f_b, s_r, s_g, s_b;
  logic        f_hs, f_vs, s_hs, s_vs;

  always #5 pixel_clk = ~pixel_clk;

  vga_timing_gen u_full (
    .pixel_clk   (pixel_clk),
    .rst_n       (rst_n),
    .h_coord     (f_h),
    .v_coord     (f_v),
    .display_on  (f_disp),
    .frame_start (f_fs),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .vga_r       (f_r),
    .vga_g       (f_g),
    .vga_b       (f_b),
    .vga_hs      (f_hs),
    .vga_vs      (f_vs)
  );

  vga_timing_gen #(
    .H_ACTIVE (SH_ACTIVE),
    .H_FP     (SH_FP),
    .H_SYNC   (SH_SYNC),
    .H_BP     (SH_BP),
    .V_ACTIVE (SV_ACTIVE),
    .V_FP     (SV_FP),
    .V_SYNC   (SV_SYNC),
    .V_BP     (SV_BP),
    .SYNC_POS (1'b0)
  ) u_small (
    .pixel_clk   (pixel_clk),
    .rst_n       (rst_n),
    .h_coord     (s_h),
    .v_coord     (s_v),
    .display_on  (s_disp),
    .frame_start (s_fs),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .vga_r       (s_r),
    .vga_g       (s_g),
    .vga_b       (s_b),
    .vga_hs      (s_hs),
    .vga_vs      (s_vs)
  );

  geom_t       full_g, small_g;
  int          n;            // clock edges since the last reset release
  logic [11:0] cur_rgb;      // colour presented for the coming edge
  logic [11:0] prev_rgb;     // colour captured at the last edge
  int          colour_mode;  // 0 random, 1 all F, 2 all zero
  int          n_checks;
  int          n_fail;

  // Expected outputs after cyc edges of free running, from raster arithmetic.
  function automatic snap_t model(input geom_t g, input int cyc, input logic [11:0] rgb);
    snap_t s;
    int ht, vt, h, v, ph, pv;
`ifdef VGA_TEST_PATTERN_EN
    int bar;
`endif
    ht = g.ha + g.hf + g.hs + g.hb;
    vt = g.va + g.vf + g.vs + g.vb;
    h = cyc % ht;
    v = (cyc / ht) % vt;
    s.h    = 11'(h);
    s.v    = 10'(v);
    s.disp = (h < g.ha) && (v < g.va);
    s.fs   = (h == 0) && (v == 0);
    s.r    = 4'h0;
    s.g    = 4'h0;
    s.b    = 4'h0;
    s.hs   = ~g.pol;
    s.vs   = ~g.pol;
    if (cyc != 0) begin
      ph = (cyc - 1) % ht;
      pv = ((cyc - 1) / ht) % vt;
      if (ph < g.ha && pv < g.va) begin
`ifdef VGA_TEST_PATTERN_EN
        bar = ph / 100;
        s.r = bar[0] ? 4'hF : 4'h0;
        s.g = bar[1] ? 4'hF : 4'h0;
        s.b = bar[2] ? 4'hF : 4'h0;
`else
        {s.r, s.g, s.b} = rgb;
`endif
      end
      if (ph >= g.ha + g.hf && ph < g.ha + g.hf + g.hs) s.hs = g.pol;
      if (pv >= g.va + g.vf && pv < g.va + g.vf + g.vs) s.vs = g.pol;
    end
    return s;
  endfunction

  function automatic snap_t obs_full();
    snap_t s;
    s = {f_h, f_v, f_disp, f_fs, f_r, f_g, f_b, f_hs, f_vs};
    return s;
  endfunction

  function automatic snap_t obs_small();
    snap_t s;
    s = {s_h, s_v, s_disp, s_fs, s_r, s_g, s_b, s_hs, s_vs};
    return s;
  endfunction

  task automatic drive_colour();
    case (colour_mode)
      0:       cur_rgb = 12'($urandom);
      1:       cur_rgb = 12'hFFF;
      default: cur_rgb = 12'h000;
    endcase
    {red, green, blue} = cur_rgb;
  endtask

  // Advance one clock; ends on the falling edge with fresh colour applied.
  task automatic step();
    @(posedge pixel_clk);
    if (rst_n) begin
      n++;
      prev_rgb = cur_rgb;
    end
    @(negedge pixel_clk);
    drive_colour();
  endtask

  task automatic test_reset();
    snap_t e, o;
    rst_n = 1'b0;
    n = 0;
    colour_mode = 0;
    drive_colour();
    prev_rgb = cur_rgb;
    repeat (3) @(negedge pixel_clk);
    e = model(full_g, 0, prev_rgb);
    o = obs_full();
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL reset_full: got %h, expected %h", o, e);
    end
    e = model(small_g, 0, prev_rgb);
    o = obs_small();
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL reset_small: got %h, expected %h", o, e);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      o = obs_full();
      n_checks++;
      if (o.h !== 11'(i) || o.v !== 10'd0 || o.fs !== (i == 0) || o.hs !== 1'b0 ||
          o.vs !== 1'b0) begin
        n_fail++;
        $display("FAIL release_full cycle %0d: got h=%0d v=%0d fs=%b hs=%b vs=%b", i, o.h, o.v,
                 o.fs, o.hs, o.vs);
      end
      o = obs_small();
      n_checks++;
      if (o.h !== 11'(i) || o.v !== 10'd0 || o.fs !== (i == 0) || o.hs !== 1'b1 ||
          o.vs !== 1'b1) begin
        n_fail++;
        $display("FAIL release_small cycle %0d: got h=%0d v=%0d fs=%b hs=%b vs=%b", i, o.h, o.v,
                 o.fs, o.hs, o.vs);
      end
      step();
    end
  endtask

  task automatic test_line_timing();
    snap_t e, o;
    int hs_cycles, first_hs_h;
    logic [10:0] last_h;
    logic [9:0] last_v;
    bit seen_wrap;
    hs_cycles = 0;
    first_hs_h = -1;
    seen_wrap = 1'b0;
    colour_mode = 0;
    last_h = f_h;
    last_v = f_v;
    while (n < 1100) begin
      step();
      e = model(full_g, n, prev_rgb);
      o = obs_full();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL line_full n=%0d: got %h, expected %h", n, o, e);
      end
      e = model(small_g, n, prev_rgb);
      n_checks++;
      if (obs_small() !== e) begin
        n_fail++;
        $display("FAIL line_small n=%0d: got %h, expected %h", n, obs_small(), e);
      end
      if (o.hs === 1'b1) begin
        if (hs_cycles == 0) first_hs_h = int'(o.h);
        hs_cycles++;
      end
      if (last_h == 11'd1023) begin
        seen_wrap = 1'b1;
        n_checks++;
        if (o.h !== 11'd0 || o.v !== last_v + 10'd1) begin
          n_fail++;
          $display("FAIL line_wrap: got h=%0d v=%0d, expected h=0 v=%0d", o.h, o.v, last_v + 1);
        end
      end
      last_h = o.h;
      last_v = o.v;
    end
    n_checks++;
    if (hs_cycles != 72) begin
      n_fail++;
      $display("FAIL hs_width: got %0d clocks, expected 72", hs_cycles);
    end
    n_checks++;
    if (first_hs_h != 825) begin
      n_fail++;
      $display("FAIL hs_start: first active at h=%0d, expected 825", first_hs_h);
    end
    n_checks++;
    if (!seen_wrap) begin
      n_fail++;
      $display("FAIL line_wrap_seen: got 0, expected 1");
    end
  endtask

  task automatic test_frame_timing();
    snap_t e, o;
    int last_fs_n, vs_cycles, target, periods;
    last_fs_n = -1;
    vs_cycles = 0;
    periods = 0;
    colour_mode = 0;
    target = n + 3 * S_HT * S_VT + 5;
    while (n < target) begin
      step();
      e = model(full_g, n, prev_rgb);
      n_checks++;
      if (obs_full() !== e) begin
        n_fail++;
        $display("FAIL frame_full n=%0d: got %h, expected %h", n, obs_full(), e);
      end
      e = model(small_g, n, prev_rgb);
      o = obs_small();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL frame_small n=%0d: got %h, expected %h", n, o, e);
      end
      if (o.vs === 1'b0) begin
        if (vs_cycles == 0 && last_fs_n >= 0) begin
          n_checks++;
          if (o.v !== 10'(SV_ACTIVE + SV_FP) || o.h !== 11'd1) begin
            n_fail++;
            $display("FAIL vs_start: got h=%0d v=%0d, expected h=1 v=%0d", o.h, o.v,
                     SV_ACTIVE + SV_FP);
          end
        end
        vs_cycles++;
      end
      if (o.fs === 1'b1) begin
        if (last_fs_n >= 0) begin
          periods++;
          n_checks++;
          if (n - last_fs_n != S_HT * S_VT) begin
            n_fail++;
            $display("FAIL fs_period: got %0d, expected %0d", n - last_fs_n, S_HT * S_VT);
          end
          n_checks++;
          if (vs_cycles != int'(SV_SYNC) * S_HT) begin
            n_fail++;
            $display("FAIL vs_width: got %0d, expected %0d", vs_cycles, int'(SV_SYNC) * S_HT);
          end
        end
        last_fs_n = n;
        vs_cycles = 0;
      end
    end
    n_checks++;
    if (periods < 2) begin
      n_fail++;
      $display("FAIL fs_seen: got %0d frame periods, expected at least 2", periods);
    end
  endtask

  task automatic test_blanking();
    snap_t e, o;
    int target;
    colour_mode = 1;
    drive_colour();
    target = n + 1100;
    while (n < target) begin
      step();
      e = model(full_g, n, prev_rgb);
      o = obs_full();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL blank_full n=%0d: got %h, expected %h", n, o, e);
      end
      if (o.h == 11'd800 && o.v < 10'd600) begin
        n_checks++;
        if (o.r !== 4'hF) begin
          n_fail++;
          $display("FAIL blank_last_active: got r=%h, expected F", o.r);
        end
      end
      if (o.h == 11'd801 && o.v < 10'd600) begin
        n_checks++;
        if ({o.r, o.g, o.b} !== 12'h000) begin
          n_fail++;
          $display("FAIL blank_h: got rgb=%h, expected 000", {o.r, o.g, o.b});
        end
      end
      e = model(small_g, n, prev_rgb);
      o = obs_small();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL blank_small n=%0d: got %h, expected %h", n, o, e);
      end
      if (o.h == 11'd1 && o.v == 10'(SV_ACTIVE)) begin
        n_checks++;
        if ({o.r, o.g, o.b} !== 12'h000) begin
          n_fail++;
          $display("FAIL blank_v: got rgb=%h, expected 000", {o.r, o.g, o.b});
        end
      end
    end
  endtask

  task automatic test_mid_frame_reset();
    snap_t e, o;
    int guard;
    colour_mode = 0;
    for (int pass = 0; pass < 2; pass++) begin
      guard = 0;
      if (pass == 0) begin
        while (f_h !== 11'd500 && guard < 2000) begin
          step();
          guard++;
        end
      end else begin
        while (!(s_v === 10'd3 && s_h === 11'd10) && guard < 2000) begin
          step();
          guard++;
        end
      end
      n_checks++;
      if (guard >= 2000) begin
        n_fail++;
        $display("FAIL reset_wait pass %0d: position not reached, got h=%0d", pass, f_h);
      end
      #2;
      rst_n = 1'b0;
      n = 0;
      #1;
      e = model(full_g, 0, prev_rgb);
      o = obs_full();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL async_clear_full pass %0d: got %h, expected %h", pass, o, e);
      end
      e = model(small_g, 0, prev_rgb);
      o = obs_small();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL async_clear_small pass %0d: got %h, expected %h", pass, o, e);
      end
      @(negedge pixel_clk);
      rst_n = 1'b1;
      for (int i = 0; i < 300; i++) begin
        step();
        e = model(full_g, n, prev_rgb);
        n_checks++;
        if (obs_full() !== e) begin
          n_fail++;
          $display("FAIL restart_full n=%0d: got %h, expected %h", n, obs_full(), e);
        end
        e = model(small_g, n, prev_rgb);
        n_checks++;
        if (obs_small() !== e) begin
          n_fail++;
          $display("FAIL restart_small n=%0d: got %h, expected %h", n, obs_small(), e);
        end
      end
    end
  endtask

  task automatic test_zero_input();
    snap_t e, o;
    logic [11:0] exp_hi;
`ifdef VGA_TEST_PATTERN_EN
    exp_hi = 12'hFFF;
`else
    exp_hi = 12'h000;
`endif
    colour_mode = 2;
    drive_colour();
    while (n < 1900) begin
      step();
      e = model(full_g, n, prev_rgb);
      o = obs_full();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL zero_full n=%0d: got %h, expected %h", n, o, e);
      end
      if (o.v < 10'd600 && o.h >= 11'd1 && o.h <= 11'd100) begin
        n_checks++;
        if ({o.r, o.g, o.b} !== 12'h000) begin
          n_fail++;
          $display("FAIL bar0 h=%0d: got rgb=%h, expected 000", o.h - 1, {o.r, o.g, o.b});
        end
      end
      if (o.v < 10'd600 && o.h >= 11'd701 && o.h <= 11'd800) begin
        n_checks++;
        if ({o.r, o.g, o.b} !== exp_hi) begin
          n_fail++;
          $display("FAIL bar7 h=%0d: got rgb=%h, expected %h", o.h - 1, {o.r, o.g, o.b}, exp_hi);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    full_g = '{ha: 800, hf: 24, hs: 72, hb: 128, va: 600, vf: 1, vs: 2, vb: 22, pol: 1'b1};
    small_g = '{ha: SH_ACTIVE, hf: SH_FP, hs: SH_SYNC, hb: SH_BP,
                va: SV_ACTIVE, vf: SV_FP, vs: SV_SYNC, vb: SV_BP, pol: 1'b0};
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_blanking();
    test_mid_frame_reset();
    test_zero_input();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
